// File: rtl/md_if.sv
`default_nettype none
// ============================================================================
//  Module      : md_if
//  Description : Controller <-> multiply/divide unit signal bundle.
//                The master side launches operations and mthi/mtlo writes;
//                the slave side (md_unit) reports busy and the HI/LO values.
//  Revision    : 1.0  initial release
// ============================================================================
interface md_if;
    logic        start;
    logic [2:0]  mdctr;
    logic [31:0] a;
    logic [31:0] b;
    logic        hiwrite;
    logic        lowrite;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mdctr, a, b, hiwrite, lowrite,
        input  busy, hi, lo
    );

    modport slave (
        input  start, mdctr, a, b, hiwrite, lowrite,
        output busy, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : Multi-cycle multiply/divide unit with HI/LO registers.
//                The 64-bit result is computed at launch and held pending;
//                a countdown emulates mult/div latency and the pending value
//                commits to HI/LO on the edge where busy falls.
//  Revision    : 1.0  initial release
// ============================================================================
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic rst,
    md_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    // Arithmetic datapath: codes 0/2 are signed, codes 2/3 are divides.
    logic        w_is_signed;
    logic        w_dvd_neg, w_dvs_neg;
    logic [31:0] w_dvd_mag, w_dvs_mag;
    logic [31:0] w_quo_mag, w_rem_mag;
    logic [31:0] w_quo, w_rem;
    logic [63:0] w_prod_s, w_prod_u;
    logic [63:0] w_result;

    // Operand preparation and result selection for the launched operation.
    always_comb begin
        w_is_signed = ~bus.mdctr[0];
        w_prod_s    = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
        w_prod_u    = {32'd0, bus.a} * {32'd0, bus.b};
        // Divide on magnitudes so INT_MIN / -1 falls out as 0x80000000 with
        // no overflow special case.
        w_dvd_neg   = w_is_signed & bus.a[31];
        w_dvs_neg   = w_is_signed & bus.b[31];
        w_dvd_mag   = w_dvd_neg ? (32'd0 - bus.a) : bus.a;
        w_dvs_mag   = w_dvs_neg ? (32'd0 - bus.b) : bus.b;
        w_quo_mag   = (w_dvs_mag == 32'd0) ? 32'd0 : (w_dvd_mag / w_dvs_mag);
        w_rem_mag   = (w_dvs_mag == 32'd0) ? 32'd0 : (w_dvd_mag % w_dvs_mag);
        w_quo       = (w_dvd_neg ^ w_dvs_neg) ? (32'd0 - w_quo_mag) : w_quo_mag;
        w_rem       = w_dvd_neg ? (32'd0 - w_rem_mag) : w_rem_mag;
        case (bus.mdctr[1:0])
            2'd0:    w_result = w_prod_s;
            2'd1:    w_result = w_prod_u;
            default: w_result = (bus.b == 32'd0) ? {hi_q, lo_q} : {w_rem, w_quo};
        endcase
    end

    // State register and all datapath flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Next-state: launch, countdown/commit, and mthi/mtlo in idle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // Reserved codes are ignored; a start always drops any
                    // simultaneous HI/LO write.
                    if (!bus.mdctr[2]) begin
                        pend_hi_d = w_result[63:32];
                        pend_lo_d = w_result[31:0];
                        cnt_d     = bus.mdctr[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_d   = S_RUN;
                    end
                end else begin
                    if (bus.hiwrite) hi_d = bus.a;
                    if (bus.lowrite) lo_d = bus.a;
                end
            end
            default: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Outputs decoded from flops only.
    always_comb begin
        bus.busy = (state_q == S_RUN);
        bus.hi   = hi_q;
        bus.lo   = lo_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_unit
//  Description : Self-checking bench for md_unit. Expected HI/LO and busy
//                length are queued at launch and compared when busy falls.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_md_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;
    localparam int TIMEOUT     = 100;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    md_if bus ();

    md_unit #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl_hi = 32'd0;
    logic [31:0] mdl_lo = 32'd0;

    // Reference model using 64-bit integer arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        exp_t            e;
        longint          sa, sb_, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(av));
        sb_ = longint'($signed(bv));
        ua = {32'd0, av};
        ub = {32'd0, bv};
        e.hi = mdl_hi;
        e.lo = mdl_lo;
        e.cyc = (op >= 3'd2) ? DIV_CYCLES : MULT_CYCLES;
        case (op)
            3'd0: begin p = longint'(sa * sb_); e.hi = p[63:32]; e.lo = p[31:0]; end
            3'd1: begin p = ua * ub;            e.hi = p[63:32]; e.lo = p[31:0]; end
            3'd2: if (bv != 0) begin q = sa / sb_; r = sa % sb_; e.hi = r[31:0]; e.lo = q[31:0]; end
            default: if (bv != 0) begin e.hi = 32'(ua % ub); e.lo = 32'(ua / ub); end
        endcase
        return e;
    endfunction

    // Drive one start pulse; legal codes queue their expected result.
    task automatic launch(input bit sync, input logic [2:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input bit hw, input bit lw);
        if (sync) @(negedge clk);
        bus.start = 1'b1; bus.mdctr = op; bus.a = av; bus.b = bv;
        bus.hiwrite = hw; bus.lowrite = lw;
        if (op < 3'd4) sb.push_back(model(op, av, bv));
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.hiwrite = 1'b0; bus.lowrite = 1'b0;
    endtask

    // mthi/mtlo write in idle.
    task automatic write_hilo(input bit hw, input bit lw, input logic [31:0] av);
        @(negedge clk);
        bus.a = av; bus.hiwrite = hw; bus.lowrite = lw;
        if (hw) mdl_hi = av;
        if (lw) mdl_lo = av;
        @(posedge clk);
        #1;
        bus.hiwrite = 1'b0; bus.lowrite = 1'b0;
    endtask

    // Count busy cycles on negedges; returns at the negedge where busy is low.
    task automatic measure(output int cyc, output bit to);
        bit done;
        cyc = 0; to = 1'b0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!bus.busy) done = 1'b1;
            else begin
                cyc++;
                if (cyc > TIMEOUT) begin to = 1'b1; done = 1'b1; end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
        checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
        rst = 1'b0;
        // Abort an in-flight mult with an asynchronous reset.
        launch(1'b1, 3'd0, 32'd5, 32'd6, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midop_rst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++; $display("FAIL midop_rst_hilo: got %h_%h expected 0_0", bus.hi, bus.lo); end
        sb.delete();
        mdl_hi = 32'd0; mdl_lo = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++; $display("FAIL midop_no_commit: got busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.hi, bus.lo); end
    endtask

    // Run a small table of operations, checking length and result of each.
    task automatic test_arith(input string name, input logic [2:0] ops[], input logic [31:0] as[], input logic [31:0] bs[]);
        int   cyc;
        bit   to;
        exp_t e;
        foreach (ops[i]) begin
            launch(1'b1, ops[i], as[i], bs[i], 1'b0, 1'b0);
            measure(cyc, to);
            e = sb.pop_front();
            mdl_hi = e.hi; mdl_lo = e.lo;
            checks++; if (to || cyc != e.cyc) begin errors++; $display("FAIL %s_busy[%0d]: got %0d cycles expected %0d", name, i, cyc, e.cyc); end
            checks++; if (bus.hi !== e.hi) begin errors++; $display("FAIL %s_hi[%0d]: got %h expected %h", name, i, bus.hi, e.hi); end
            checks++; if (bus.lo !== e.lo) begin errors++; $display("FAIL %s_lo[%0d]: got %h expected %h", name, i, bus.lo, e.lo); end
        end
    endtask

    task automatic test_mthi_mtlo;
        write_hilo(1'b1, 1'b0, 32'h11);
        write_hilo(1'b0, 1'b1, 32'h22);
        @(negedge clk);
        checks++; if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
            errors++; $display("FAIL mthi_mtlo: got %h_%h expected 00000011_00000022", bus.hi, bus.lo); end
        write_hilo(1'b1, 1'b1, 32'h33);
        @(negedge clk);
        checks++; if (bus.hi !== 32'h33 || bus.lo !== 32'h33) begin
            errors++; $display("FAIL both_write: got %h_%h expected 00000033_00000033", bus.hi, bus.lo); end
        write_hilo(1'b1, 1'b0, 32'h11);
        write_hilo(1'b0, 1'b1, 32'h22);
    endtask

    task automatic test_conflicts;
        int          cyc;
        bit          done;
        exp_t        e;
        logic [31:0] pre_hi, pre_lo;
        pre_hi = mdl_hi;
        launch(1'b1, 3'd0, 32'd3, 32'd4, 1'b0, 1'b0);
        cyc = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!bus.busy || cyc > TIMEOUT) done = 1'b1;
            else begin
                cyc++;
                if (cyc == 2) begin
                    bus.start = 1'b1; bus.mdctr = 3'd0; bus.a = 32'hDEAD; bus.b = 32'd1; bus.hiwrite = 1'b1;
                end else if (cyc == 3) begin
                    bus.start = 1'b0; bus.hiwrite = 1'b0;
                    checks++; if (bus.hi !== pre_hi) begin errors++; $display("FAIL busy_hiwrite: got %h expected %h", bus.hi, pre_hi); end
                end
            end
        end
        e = sb.pop_front();
        mdl_hi = e.hi; mdl_lo = e.lo;
        checks++; if (cyc != e.cyc) begin errors++; $display("FAIL busy_restart_len: got %0d expected %0d", cyc, e.cyc); end
        checks++; if (bus.hi !== e.hi || bus.lo !== e.lo) begin
            errors++; $display("FAIL busy_restart_res: got %h_%h expected %h_%h", bus.hi, bus.lo, e.hi, e.lo); end
        // start with lowrite in the same idle cycle: the write is dropped.
        pre_lo = mdl_lo;
        launch(1'b1, 3'd0, 32'h1234, 32'd2, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (bus.lo !== pre_lo || bus.busy !== 1'b1) begin
            errors++; $display("FAIL start_lowrite_drop: got lo=%h busy=%b expected lo=%h busy=1", bus.lo, bus.busy, pre_lo); end
        measure(cyc, done);
        e = sb.pop_front();
        mdl_hi = e.hi; mdl_lo = e.lo;
        checks++; if (done || cyc != e.cyc - 1 || bus.hi !== e.hi || bus.lo !== e.lo) begin
            errors++; $display("FAIL start_lowrite_res: got %0d/%h_%h expected %0d/%h_%h", cyc, bus.hi, bus.lo, e.cyc - 1, e.hi, e.lo); end
    endtask

    task automatic test_back_to_back;
        int   cyc;
        bit   to;
        exp_t e;
        launch(1'b1, 3'd1, 32'd3, 32'd5, 1'b0, 1'b0);
        measure(cyc, to);
        e = sb.pop_front();
        mdl_hi = e.hi; mdl_lo = e.lo;
        checks++; if (to || cyc != e.cyc || bus.lo !== e.lo) begin
            errors++; $display("FAIL b2b_first: got %0d/%h expected %0d/%h", cyc, bus.lo, e.cyc, e.lo); end
        // Same negedge busy was seen low: launch with no gap.
        launch(1'b0, 3'd1, 32'hFFFFFFFF, 32'd3, 1'b0, 1'b0);
        measure(cyc, to);
        e = sb.pop_front();
        mdl_hi = e.hi; mdl_lo = e.lo;
        checks++; if (to || cyc != e.cyc) begin errors++; $display("FAIL b2b_len: got %0d expected %0d", cyc, e.cyc); end
        checks++; if (bus.hi !== e.hi || bus.lo !== e.lo) begin
            errors++; $display("FAIL b2b_res: got %h_%h expected %h_%h", bus.hi, bus.lo, e.hi, e.lo); end
        // Reserved code: nothing happens.
        launch(1'b1, 3'd5, 32'd9, 32'd9, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            checks++; if (bus.busy !== 1'b0 || bus.hi !== mdl_hi || bus.lo !== mdl_lo) begin
                errors++; $display("FAIL reserved_op: got busy=%b hi=%h lo=%h expected 0/%h/%h", bus.busy, bus.hi, bus.lo, mdl_hi, mdl_lo); end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.mdctr = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
        bus.hiwrite = 1'b0; bus.lowrite = 1'b0;
        rst = 1'b1;
        test_reset();
        test_arith("mult", '{3'd0, 3'd1}, '{32'hFFFFFFFD, 32'hFFFFFFFF}, '{32'd7, 32'd2});
        test_arith("div",  '{3'd2, 3'd3}, '{32'hFFFFFFF9, 32'd7}, '{32'd2, 32'd2});
        test_mthi_mtlo();
        test_arith("divspecial", '{3'd2, 3'd2}, '{32'd9, 32'h80000000}, '{32'd0, 32'hFFFFFFFF});
        test_conflicts();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
